// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock front-panel logic.
package alarm_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_HELD,
    BTN_REPEAT
  } btn_state_t;

  localparam int unsigned CLK_FREQ_HZ = 38_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lowest_first_enc.sv
// Combinational lowest-set-bit encoder used to pick which pressed button is granted.
module lowest_first_enc #(
  parameter int unsigned NBTN = 4
) (
  input  logic [NBTN-1:0]         req,
  output logic                    valid,
  output logic [$clog2(NBTN)-1:0] idx
);

  localparam int unsigned IW = $clog2(NBTN);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = NBTN; i > 0; i--) begin
      if (req[i-1]) begin
        valid = 1'b1;
        idx   = IW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Grants one debounced button at a time and emits single-cycle press, long,
// auto-repeat and release pulses for the owning button.
module button_event_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned NBTN          = 4,
  parameter int unsigned LONG_CYCLES   = CLK_FREQ_HZ,
  parameter int unsigned REPEAT_CYCLES = CLK_FREQ_HZ / 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NBTN-1:0]         btn_db,
  output logic [NBTN-1:0]         press_pulse,
  output logic [NBTN-1:0]         long_pulse,
  output logic [NBTN-1:0]         repeat_pulse,
  output logic [NBTN-1:0]         release_pulse,
  output logic [$clog2(NBTN)-1:0] held_idx,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(NBTN);
  localparam int unsigned CW = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  btn_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NBTN-1:0] btn_prev_q, btn_prev_d;
  logic [NBTN-1:0] press_q, press_d;
  logic [NBTN-1:0] long_q, long_d;
  logic [NBTN-1:0] rep_q, rep_d;
  logic [NBTN-1:0] rel_q, rel_d;
  logic            busy_q, busy_d;

  logic [NBTN-1:0] rise;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;

  assign rise = btn_db & ~btn_prev_q;

  lowest_first_enc #(.NBTN(NBTN)) u_grant_enc (
    .req   (rise),
    .valid (grant_valid),
    .idx   (grant_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    btn_prev_d = btn_db;
    press_d    = '0;
    long_d     = '0;
    rep_d      = '0;
    rel_d      = '0;

    unique case (state_q)
      BTN_IDLE: begin
        if (grant_valid) begin
          press_d[grant_idx] = 1'b1;
          idx_d              = grant_idx;
          cnt_d              = '0;
          state_d            = BTN_HELD;
        end
      end
      BTN_HELD, BTN_REPEAT: begin
        if (!btn_db[idx_q]) begin
          rel_d[idx_q] = 1'b1;
          cnt_d        = '0;
          // A fresh rise on the release edge is handed off without passing through idle.
          if (grant_valid) begin
            press_d[grant_idx] = 1'b1;
            idx_d              = grant_idx;
            state_d            = BTN_HELD;
          end else begin
            idx_d   = '0;
            state_d = BTN_IDLE;
          end
        end else if (state_q == BTN_HELD && cnt_q == LONG_LAST) begin
          long_d[idx_q] = 1'b1;
          cnt_d         = '0;
          state_d       = BTN_REPEAT;
        end else if (state_q == BTN_REPEAT && cnt_q == REP_LAST) begin
          rep_d[idx_q] = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = BTN_IDLE;
    endcase

    busy_d = (state_d != BTN_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BTN_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      btn_prev_q <= '1;
      press_q    <= '0;
      long_q     <= '0;
      rep_q      <= '0;
      rel_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
      rel_q      <= rel_d;
      busy_q     <= busy_d;
    end
  end

  assign press_pulse   = press_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;
  assign release_pulse = rel_q;
  assign held_idx      = idx_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed vector bench for button_event_ctrl with NBTN=4, LONG=8, REPEAT=3.
module tb_button_event_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] btn_db;
  logic [3:0] press_pulse, long_pulse, repeat_pulse, release_pulse;
  logic [1:0] held_idx;
  logic       busy;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic [3:0] btn;
    logic [3:0] press;
    logic [3:0] lng;
    logic [3:0] rep;
    logic [3:0] rel;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  button_event_ctrl #(
    .NBTN          (4),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_db        (btn_db),
    .press_pulse   (press_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .held_idx      (held_idx),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] outs();
    return {press_pulse, long_pulse, repeat_pulse, release_pulse, held_idx, busy};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got press/long/rep/rel/idx/busy=%b required %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] btn, input logic [3:0] press, input logic [3:0] lng,
                     input logic [3:0] rep, input logic [3:0] rel, input logic [1:0] idx,
                     input logic busy);
    vec_t v;
    v.btn = btn; v.press = press; v.lng = lng; v.rep = rep; v.rel = rel; v.idx = idx; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic step_check(input string name, input logic [3:0] btn, input logic [18:0] exp);
    btn_db = btn;
    @(posedge clk);
    #1;
    check(name, outs(), exp);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // Held through reset: no press; drop and re-raise btn0 gives a press.
    for (int i = 0; i < 3; i++) add(4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    add(4'b1110, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    add(4'b1111, 4'b0001, 4'b0, 4'b0, 4'b0, 2'd0, 1'b1);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b0);

    // Short press of btn2.
    add(4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 2'd2, 1'b1);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0100, 2'd0, 1'b0);

    // Long hold of btn1: long at +8, repeats at +11/+14/+17, release at +20 beats repeat.
    for (int j = 0; j < 20; j++)
      add(4'b0010, (j == 0) ? 4'b0010 : 4'b0, (j == 8) ? 4'b0010 : 4'b0,
          (j == 11 || j == 14 || j == 17) ? 4'b0010 : 4'b0, 4'b0, 2'd1, 1'b1);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0010, 2'd0, 1'b0);

    // Release on the exact edge long would fire: release only.
    for (int j = 0; j < 8; j++)
      add(4'b0010, (j == 0) ? 4'b0010 : 4'b0, 4'b0, 4'b0, 4'b0, 2'd1, 1'b1);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0010, 2'd0, 1'b0);

    // Simultaneous rise of btn0/btn3: lowest wins; btn3 needs a re-press.
    add(4'b1001, 4'b0001, 4'b0, 4'b0, 4'b0, 2'd0, 1'b1);
    add(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0001, 2'd0, 1'b0);
    add(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    add(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    add(4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0, 2'd3, 1'b1);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b1000, 2'd0, 1'b0);

    // Handoff btn0 -> btn2 on the same edge.
    add(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 2'd0, 1'b1);
    add(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 2'd0, 1'b1);
    add(4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0001, 2'd2, 1'b1);
    add(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 2'd2, 1'b1);
    add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0100, 2'd0, 1'b0);

    reset  = 1'b0;
    btn_db = 4'b1111;
    #2;
    check("reset_async", outs(), '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), '0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      btn_db = vecs[i].btn;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), outs(),
            {vecs[i].press, vecs[i].lng, vecs[i].rep, vecs[i].rel, vecs[i].idx, vecs[i].busy});
    end

    // Reset asserted mid-REPEAT clears everything asynchronously, no release afterwards.
    step_check("mr_press", 4'b0010, {4'b0010, 4'b0, 4'b0, 4'b0, 2'd1, 1'b1});
    for (int j = 1; j < 11; j++) begin
      btn_db = 4'b0010;
      @(posedge clk);
    end
    #1;
    check("mr_long_state", outs(), {4'b0, 4'b0, 4'b0, 4'b0, 2'd1, 1'b1});
    step_check("mr_repeat", 4'b0010, {4'b0, 4'b0, 4'b0010, 4'b0, 2'd1, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    check("mr_async_clear", outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    check("mr_in_reset", outs(), '0);
    reset = 1'b1;
    for (int j = 0; j < 15; j++)
      step_check($sformatf("mr_quiet[%0d]", j), 4'b0010, '0);
    step_check("mr_no_release", 4'b0000, '0);
    step_check("mr_repress", 4'b0010, {4'b0010, 4'b0, 4'b0, 4'b0, 2'd1, 1'b1});
    step_check("mr_final_rel", 4'b0000, {4'b0, 4'b0, 4'b0, 4'b0010, 2'd0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
